// File: rtl/vga_timing_640x480.sv
// VGA 640x480 timing generator: pixel divider, h/v counters, registered sync/blank decode.
// Outputs are registered and aligned with hcount/vcount; there is no backpressure.
module vga_timing_640x480 #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [7:0]  frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [4:0]  div_q, div_d;
    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_q, blank_d;
    logic        pix_tick_q, pix_tick_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        advance;
    logic        frame_wrap;

    always_comb begin
        advance       = (div_q == DIV_LAST);
        frame_wrap    = 1'b0;
        div_d         = advance ? 5'd0 : div_q + 5'd1;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_count_d = frame_count_q;

        if (advance) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 11'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d   = 11'd0;
                    frame_wrap = 1'b1;
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end

        if (frame_wrap) begin
            frame_count_d = frame_count_q + 8'd1;
        end

        // Decode from the next counter values so the registered syncs line up with the counters.
        hsync_d       = !((hcount_d >= HS_START) && (hcount_d < HS_END));
        vsync_d       = !((vcount_d >= VS_START) && (vcount_d < VS_END));
        blank_d       = (hcount_d >= H_ACT) || (vcount_d >= V_ACT);
        pix_tick_d    = advance;
        frame_start_d = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= 5'd0;
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign pix_tick    = pix_tick_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_640x480.sv
// Bench for vga_timing_640x480: three instances (full 640x480 at /4, tiny raster at /1 and /4)
// compared every cycle against an elapsed-edge arithmetic model through per-instance queues.
module tb_vga_timing_640x480;
    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        pt;
        logic        fs;
        logic [7:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Expected outputs after n rising edges out of reset, from the raster rules alone.
    function automatic exp_t model(input int n, input int d,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb);
        exp_t e;
        int ht, vt, p, h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = n / d;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.h  = 11'(h);
        e.v  = 11'(v);
        e.hs = !(h >= ha + hf && h < ha + hf + hs);
        e.vs = !(v >= va + vf && v < va + vf + vs);
        e.bl = (h >= ha) || (v >= va);
        e.pt = (n >= 1) && (n % d == 0);
        e.fs = e.pt && (p % (ht * vt) == 0);
        e.fc = 8'((p / (ht * vt)) % 256);
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam bit SMALL = (g != 0);
        localparam int D  = (g == 1) ? 1 : 4;
        localparam int HA = SMALL ? 4 : 640;
        localparam int HF = SMALL ? 1 : 16;
        localparam int HS = SMALL ? 2 : 96;
        localparam int HB = SMALL ? 1 : 48;
        localparam int VA = SMALL ? 3 : 480;
        localparam int VF = SMALL ? 1 : 10;
        localparam int VS = SMALL ? 1 : 2;
        localparam int VB = SMALL ? 1 : 33;

        logic [10:0] hc, vc;
        logic        hs, vs, bl, pt, fs;
        logic [7:0]  fc;
        int          n = 0;
        int          total = 0;
        int          bad = 0;
        exp_t        q[$];

        vga_timing_640x480 #(
            .CLK_DIV(D),
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .hcount(hc),
            .vcount(vc),
            .hsync(hs),
            .vsync(vs),
            .blank(bl),
            .pix_tick(pt),
            .frame_start(fs),
            .frame_count(fc)
        );

        always @(posedge clk or posedge rst) begin
            if (rst) n = 0;
            else     n = n + 1;
        end

        always @(negedge clk) begin
            q.push_back(model(n, D, HA, HF, HS, HB, VA, VF, VS, VB));
        end

        always @(negedge clk) begin
            exp_t a, e;
            #1;
            a = {hc, vc, hs, vs, bl, pt, fs, fc};
            total = total + 1;
            checks = checks + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                errors = errors + 1;
                $display("FAIL inst%0d scoreboard_empty at t=%0t", g, $time);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    bad = bad + 1;
                    errors = errors + 1;
                    if (bad <= 20)
                        $display("FAIL inst%0d outputs t=%0t got h=%0d v=%0d hs=%b vs=%b bl=%b pt=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b bl=%b pt=%b fs=%b fc=%0d",
                                 g, $time, a.h, a.v, a.hs, a.vs, a.bl, a.pt, a.fs, a.fc,
                                 e.h, e.v, e.hs, e.vs, e.bl, e.pt, e.fs, e.fc);
                end
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk);
        #($urandom_range(1, 4));
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Random mid-line / mid-frame asynchronous resets.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(30, 500)) @(posedge clk);
            pulse_reset();
        end

        // Long enough for the /4 tiny raster (192 clk/frame) to pass 256 frames and wrap frame_count.
        repeat (256 * 192 + 400) @(posedge clk);

        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", checks, errors);
        $finish;
    end
endmodule
